// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: receive side of the servo-style PWM link.
// Synchronises pwm_in, measures each high pulse in ticks (rounded to the
// nearest tick, halves up) and maps (speed+MIN_TICKS) ticks to a 3-bit code.
// Malformed or stuck-high pulses raise err; a long silent line drops locked.
module servo_pwm_decoder #(
  parameter int TICK_CYCLES    = 25000,
  parameter int MIN_TICKS      = 2,
  parameter int MAX_HIGH_TICKS = 16,
  parameter int TIMEOUT_TICKS  = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [2:0] speed,
  output logic       valid,
  output logic       err,
  output logic       locked
);

  localparam int SUB_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TICK_TOP = (MAX_HIGH_TICKS > TIMEOUT_TICKS) ? MAX_HIGH_TICKS : TIMEOUT_TICKS;
  localparam int TICK_W   = $clog2(TICK_TOP + 1);
  // high_cycles never exceeds MAX_HIGH_TICKS*TICK_CYCLES+1 before the stuck exit
  localparam int HC_W     = $clog2((MAX_HIGH_TICKS + 1) * TICK_CYCLES + 1);

  localparam logic [SUB_W-1:0]  SUB_LAST      = SUB_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] HIGH_LIMIT    = TICK_W'(MAX_HIGH_TICKS);
  localparam logic [TICK_W-1:0] TIMEOUT_LIMIT = TICK_W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_WAIT = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  logic s1_reg, s2_reg, prev_reg;
  logic rise, fall;

  state_t            state_reg, state_next;
  logic [SUB_W-1:0]  sub_cnt_reg, sub_cnt_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [HC_W-1:0]   high_cycles_reg, high_cycles_next;
  logic [2:0]        speed_reg, speed_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;
  logic              locked_reg, locked_next;

  logic              wrap;
  logic [SUB_W-1:0]  sub_adv;
  logic [TICK_W-1:0] tick_inc, tick_adv;
  logic [31:0]       w_ticks;
  logic              w_in_range;

  assign rise = s2_reg & ~prev_reg;
  assign fall = ~s2_reg & prev_reg;

  // Two-flop synchroniser plus one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      s1_reg   <= pwm_in;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  // Tick counter advance and rounded pulse width, shared by the FSM
  always_comb begin
    wrap       = (sub_cnt_reg == SUB_LAST);
    sub_adv    = wrap ? '0 : sub_cnt_reg + SUB_W'(1);
    tick_inc   = tick_cnt_reg + TICK_W'(1);
    tick_adv   = wrap ? tick_inc : tick_cnt_reg;
    w_ticks    = (32'(high_cycles_reg) + 32'(TICK_CYCLES / 2)) / 32'(TICK_CYCLES);
    w_in_range = (w_ticks >= 32'(MIN_TICKS)) && (w_ticks <= 32'(MIN_TICKS + 7));
  end

  // Next-state and output decode; counters clear whenever a state is entered
  always_comb begin
    state_next       = state_reg;
    sub_cnt_next     = sub_cnt_reg;
    tick_cnt_next    = tick_cnt_reg;
    high_cycles_next = high_cycles_reg;
    speed_next       = speed_reg;
    valid_next       = 1'b0;
    err_next         = 1'b0;
    locked_next      = locked_reg;

    case (state_reg)
      S_SYNC: begin
        sub_cnt_next  = '0;
        tick_cnt_next = '0;
        if (!s2_reg) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise) begin
          // the rise cycle itself is the first high cycle
          state_next       = S_HIGH;
          sub_cnt_next     = '0;
          tick_cnt_next    = '0;
          high_cycles_next = HC_W'(1);
        end else if (tick_cnt_reg == TIMEOUT_LIMIT) begin
          // counters parked at the timeout value until the next rise
          locked_next = 1'b0;
        end else begin
          sub_cnt_next  = sub_adv;
          tick_cnt_next = tick_adv;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_next    = S_WAIT;
          sub_cnt_next  = '0;
          tick_cnt_next = '0;
          if (w_in_range) begin
            speed_next  = 3'(w_ticks - 32'(MIN_TICKS));
            valid_next  = 1'b1;
            locked_next = 1'b1;
          end else begin
            err_next    = 1'b1;
            locked_next = 1'b0;
          end
        end else if (wrap && (tick_inc == HIGH_LIMIT)) begin
          // stuck high: resynchronise on the next low level
          state_next    = S_SYNC;
          sub_cnt_next  = '0;
          tick_cnt_next = '0;
          err_next      = 1'b1;
          locked_next   = 1'b0;
        end else begin
          sub_cnt_next     = sub_adv;
          tick_cnt_next    = tick_adv;
          high_cycles_next = high_cycles_reg + HC_W'(1);
        end
      end
      default: begin
        state_next    = S_SYNC;
        sub_cnt_next  = '0;
        tick_cnt_next = '0;
      end
    endcase
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_SYNC;
      sub_cnt_reg     <= '0;
      tick_cnt_reg    <= '0;
      high_cycles_reg <= '0;
      speed_reg       <= 3'd0;
      valid_reg       <= 1'b0;
      err_reg         <= 1'b0;
      locked_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sub_cnt_reg     <= sub_cnt_next;
      tick_cnt_reg    <= tick_cnt_next;
      high_cycles_reg <= high_cycles_next;
      speed_reg       <= speed_next;
      valid_reg       <= valid_next;
      err_reg         <= err_next;
      locked_reg      <= locked_next;
    end
  end

  assign speed  = speed_reg;
  assign valid  = valid_reg;
  assign err    = err_reg;
  assign locked = locked_reg;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: directed scenarios followed by random pulses,
// each checked against a pulse-level model (rounded width -> speed/err/locked).
module tb_servo_pwm_decoder;

  localparam int TICK    = 10;
  localparam int MIN_T   = 2;
  localparam int MAX_HI  = 16;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [2:0] speed;
  logic       valid, err, locked;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  logic [2:0] prev_speed = 3'd0;

  int model_speed = 0;
  int model_locked = 0;

  servo_pwm_decoder #(
    .TICK_CYCLES(TICK),
    .MIN_TICKS(MIN_T),
    .MAX_HIGH_TICKS(MAX_HI),
    .TIMEOUT_TICKS(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .speed(speed),
    .valid(valid),
    .err(err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event monitor: counts valid/err pulses and checks per-cycle invariants
  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (valid === 1'b1 || err === 1'b1) check("valid_err_exclusive", {31'd0, valid & err}, 0);
    if (rst_n && (speed !== prev_speed)) check("speed_changes_only_with_valid", {31'd0, valid}, 1);
    prev_speed = speed;
  end

  // Drive one high pulse of n cycles followed by gap low cycles
  task automatic drive_pulse(input int n, input int gap);
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Apply a pulse and compare against the rounded-width model
  task automatic run_pulse(input string tag, input int n, input int gap);
    int v0, e0, w, ev, ee;
    v0 = valid_cnt;
    e0 = err_cnt;
    w = (n + TICK / 2) / TICK;
    if (w >= MIN_T && w <= MIN_T + 7) begin
      model_speed = w - MIN_T;
      model_locked = 1;
      ev = 1; ee = 0;
    end else begin
      model_locked = 0;
      ev = 0; ee = 1;
    end
    drive_pulse(n, gap);
    $display("%s: high=%0d w=%0d speed=%0d valid+%0d err+%0d locked=%0d",
             tag, n, w, speed, valid_cnt - v0, err_cnt - e0, locked);
    check({tag, "_valid"}, valid_cnt - v0, ev);
    check({tag, "_err"}, err_cnt - e0, ee);
    check({tag, "_speed"}, {29'd0, speed}, model_speed);
    check({tag, "_locked"}, {31'd0, locked}, model_locked);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, t0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_speed", {29'd0, speed}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1) basic decode
    run_pulse("p30", 30, 100);
    run_pulse("p40", 40, 100);
    run_pulse("p90", 90, 100);
    // 2) rounding boundary
    run_pulse("p24", 24, 100);
    run_pulse("p25", 25, 100);
    // 3) out of range
    run_pulse("p14", 14, 100);
    run_pulse("p100", 100, 100);

    // 4) stuck high
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clk); #1 pwm_in = 1'b1;
    t0 = cyc;
    repeat (200) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    model_locked = 0;
    $display("stuck: high=200 err+%0d valid+%0d err_at=%0d locked=%0d",
             err_cnt - e0, valid_cnt - v0, err_cyc - t0, locked);
    check("stuck_err", err_cnt - e0, 1);
    check("stuck_valid", valid_cnt - v0, 0);
    check("stuck_err_time", {31'd0, (err_cyc - t0 >= 158) && (err_cyc - t0 <= 166)}, 1);
    check("stuck_locked", {31'd0, locked}, 0);
    check("stuck_speed", {29'd0, speed}, model_speed);
    run_pulse("after_stuck", 30, 100);

    // 5) loss of signal
    run_pulse("pre_timeout", 40, 10);
    v0 = valid_cnt; e0 = err_cnt;
    repeat (180) @(posedge clk);
    #1;
    check("timeout_locked_before", {31'd0, locked}, 1);
    repeat (30) @(posedge clk);
    #1;
    $display("timeout: low=220 locked=%0d speed=%0d", locked, speed);
    check("timeout_locked_after", {31'd0, locked}, 0);
    check("timeout_speed", {29'd0, speed}, model_speed);
    check("timeout_events", (valid_cnt - v0) + (err_cnt - e0), 0);
    model_locked = 0;

    // reset mid-pulse
    run_pulse("pre_reset", 30, 100);
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_speed", {29'd0, speed}, 0);
    check("midrst_valid", {31'd0, valid}, 0);
    check("midrst_err", {31'd0, err}, 0);
    check("midrst_locked", {31'd0, locked}, 0);
    repeat (20) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    $display("midreset: valid+%0d err+%0d", valid_cnt - v0, err_cnt - e0);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    model_speed = 0;
    model_locked = 0;

    // 6) random pulses
    for (int i = 0; i < 40; i++) begin
      run_pulse("rnd", int'($urandom_range(1, 150)), int'($urandom_range(6, 120)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
